// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - parses A5/X/Y/LEN/payload UART packets into framebuffer pixel writes
// Optional trailing CHK byte enabled by defining UART_FRAME_LOADER_CHECKSUM_EN.
module uart_frame_loader #(
  parameter int FB_WIDTH       = 128,
  parameter int FB_HEIGHT      = 32,
  parameter int TIMEOUT_CYCLES = 480000
) (
  input  logic                         clk_48mhz,
  input  logic                         reset,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         wr_en,
  output logic [$clog2(FB_WIDTH)-1:0]  wr_x,
  output logic [$clog2(FB_HEIGHT)-1:0] wr_y,
  output logic [7:0]                   wr_data,
  output logic                         busy,
  output logic [7:0]                   err_count
);
  localparam int XW = $clog2(FB_WIDTH);
  localparam int YW = $clog2(FB_HEIGHT);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {
    IDLE, HDR_X, HDR_Y, HDR_LEN, DATA,
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    CHK,
`endif
    REPLY
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   cur_x;
  logic [YW-1:0]   cur_y;
  logic [8:0]      rem_q;
  logic            bad_q;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_active, timed_out, pixel_fire, reply_go, reply_bad, handshake;

`ifdef UART_FRAME_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, chk_sum;
  assign chk_sum = sum_q + rx_data;
`endif

  assign tx_valid = (state_q == REPLY);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk_48mhz) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pixel_fire = 1'b0;
    reply_go   = 1'b0;
    reply_bad  = bad_q;
    handshake  = 1'b0;
    timed_out  = 1'b0;
    tmo_active = (state_q != IDLE) && (state_q != REPLY);
    if (tmo_active && !rx_valid && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      timed_out = 1'b1;
      state_d   = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rx_valid && rx_data == SYNC) state_d = HDR_X;
        HDR_X:   if (rx_valid) state_d = HDR_Y;
        HDR_Y:   if (rx_valid) state_d = HDR_LEN;
        HDR_LEN: if (rx_valid) state_d = DATA;
        DATA: if (rx_valid) begin
          pixel_fire = !bad_q;
          if (rem_q == 9'd1) begin
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d  = REPLY;
            reply_go = 1'b1;
`endif
          end
        end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
        CHK: if (rx_valid) begin
          state_d   = REPLY;
          reply_go  = 1'b1;
          reply_bad = bad_q || (chk_sum != 8'h00);
        end
`endif
        REPLY: if (tx_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      cur_x     <= '0;
      cur_y     <= '0;
      rem_q     <= '0;
      bad_q     <= 1'b0;
      tmo_cnt   <= '0;
      tx_data   <= 8'h00;
      wr_en     <= 1'b0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_data   <= 8'h00;
      err_count <= 8'h00;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
      sum_q     <= 8'h00;
`endif
    end else begin
      wr_en <= pixel_fire;
      if (!tmo_active || rx_valid) tmo_cnt <= '0;
      else                         tmo_cnt <= tmo_cnt + TW'(1);

      if (rx_valid) begin
        case (state_q)
          HDR_X: begin
            cur_x <= rx_data[XW-1:0];
            bad_q <= (32'(rx_data) >= FB_WIDTH);
          end
          HDR_Y: begin
            cur_y <= rx_data[YW-1:0];
            if (32'(rx_data) >= FB_HEIGHT) bad_q <= 1'b1;
          end
          HDR_LEN: rem_q <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          DATA:    rem_q <= rem_q - 9'd1;
          default: ;
        endcase
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
        // Running sum starts at X so the CHK byte brings a clean packet to zero.
        if (state_q == HDR_X) sum_q <= rx_data;
        else                  sum_q <= chk_sum;
`endif
      end

      if (pixel_fire) begin
        wr_x    <= cur_x;
        wr_y    <= cur_y;
        wr_data <= rx_data;
        cur_x   <= cur_x + XW'(1);
        if (cur_x == XW'(FB_WIDTH - 1)) cur_y <= cur_y + YW'(1);
      end

      if (reply_go) tx_data <= reply_bad ? NAK : ACK;

      if ((timed_out || (handshake && tx_data == NAK)) && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - randomized self-checking bench for uart_frame_loader
module tb_uart_frame_loader;
  localparam int W  = 128;
  localparam int H  = 32;
  localparam int XW = 7;
  localparam int YW = 5;
  localparam int T  = 3000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_ready = 1'b0;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          wr_en;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [7:0]    wr_data;
  logic          busy;
  logic [7:0]    err_count;

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  int err_exp = 0;
  int max_gap = 3;
  logic [7:0] pl [0:255];

  uart_frame_loader #(.FB_WIDTH(W), .FB_HEIGHT(H), .TIMEOUT_CYCLES(T)) dut (
    .clk_48mhz(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en === 1'b1) wr_seen <= wr_seen + 1;

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic put_byte(input logic [7:0] b);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_packet(input logic [7:0] px, input logic [7:0] py, input int len,
                             input int chk_force, input int stall, input bit poke);
    logic [7:0] lb, sum, chk, rep;
    bit coord_ok, ack, stable;
    int w0, lin, ex, ey;
    lb = len[7:0];
    coord_ok = (int'(px) < W) && (int'(py) < H);
    sum = px + py + lb;
    for (int i = 0; i < len; i++) sum = sum + pl[i];
    chk = (chk_force >= 0) ? chk_force[7:0] : (8'h00 - sum);
    ack = coord_ok;
    w0 = wr_seen;
    put_byte(8'hA5); put_byte(px); put_byte(py); put_byte(lb);
    for (int i = 0; i < len; i++) begin
      put_byte(pl[i]);
      lin = int'(py) * W + int'(px) + i;
      ex = lin % W;
      ey = (lin / W) % H;
      checks++;
      if (coord_ok) begin
        if (wr_en !== 1'b1 || wr_x !== XW'(ex) || wr_y !== YW'(ey) || wr_data !== pl[i]) begin
          failures++;
          $display("FAIL pixel[%0d] got en=%b (%0d,%0d)=%02h required en=1 (%0d,%0d)=%02h",
                   i, wr_en, wr_x, wr_y, wr_data, ex, ey, pl[i]);
        end
      end else if (wr_en !== 1'b0) begin
        failures++;
        $display("FAIL bad_pkt_write[%0d] got wr_en=%b required 0", i, wr_en);
      end
    end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    put_byte(chk);
    if (8'(sum + chk) != 8'h00) ack = 1'b0;
`endif
    rep = ack ? 8'h06 : 8'h15;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== rep) begin
      failures++;
      $display("FAIL reply got valid=%b data=%02h required valid=1 data=%02h (chk %02h)",
               tx_valid, tx_data, rep, chk);
    end
    stable = 1'b1;
    for (int c = 0; c < stall; c++) begin
      if (poke && c == 0) begin
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      if (tx_valid !== 1'b1 || tx_data !== rep) stable = 1'b0;
    end
    if (stall > 0) begin
      checks++;
      if (!stable) begin
        failures++;
        $display("FAIL reply_hold got valid=%b data=%02h required stable valid=1 data=%02h",
                 tx_valid, tx_data, rep);
      end
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    if (!ack && err_exp < 255) err_exp++;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL handshake got tx_valid=%b busy=%b required 0 0", tx_valid, busy);
    end
    checks++;
    if (err_count !== 8'(err_exp)) begin
      failures++;
      $display("FAIL err_count got %0d required %0d", err_count, err_exp);
    end
    checks++;
    if (wr_seen - w0 != (coord_ok ? len : 0)) begin
      failures++;
      $display("FAIL write_count got %0d required %0d", wr_seen - w0, coord_ok ? len : 0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || wr_en !== 1'b0 || wr_x !== '0 ||
        wr_y !== '0 || wr_data !== 8'h00 || err_count !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s got tv=%b td=%02h we=%b x=%0d y=%0d wd=%02h err=%0d busy=%b required all 0",
               tag, tx_valid, tx_data, wr_en, wr_x, wr_y, wr_data, err_count, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    reset = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");
  endtask

  task automatic test_basic;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_packet(8'h00, 8'h00, 3, -1, 0, 1'b0);
  endtask

  task automatic test_wrap;
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    send_packet(8'h7F, 8'h1F, 2, -1, 2, 1'b0);
  endtask

  task automatic test_bad_coord;
    pl[0] = 8'h55;
    send_packet(8'h80, 8'h00, 1, -1, 1, 1'b0);
    checks++;
    if (err_count !== 8'd1) begin
      failures++;
      $display("FAIL bad_coord_err got %0d required 1", err_count);
    end
    pl[0] = 8'h66;
    send_packet(8'h00, 8'h20, 1, -1, 0, 1'b0);
  endtask

  task automatic test_timeout;
    int cnt, w0;
    bit saw_tx;
    w0 = wr_seen;
    put_byte(8'hA5);
    put_byte(8'h05);
    cnt = 0;
    saw_tx = 1'b0;
    while (busy === 1'b1 && cnt < T + 10) begin
      @(negedge clk);
      cnt++;
      if (tx_valid !== 1'b0) saw_tx = 1'b1;
    end
    err_exp++;
    checks++;
    if (cnt != T) begin
      failures++;
      $display("FAIL timeout_cycles got %0d required %0d", cnt, T);
    end
    checks++;
    if (saw_tx || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_tx got tx seen=%b required none", saw_tx);
    end
    checks++;
    if (err_count !== 8'(err_exp) || wr_seen != w0) begin
      failures++;
      $display("FAIL timeout_err got err=%0d writes=%0d required err=%0d writes=0",
               err_count, wr_seen - w0, err_exp);
    end
  endtask

  task automatic test_checksum;
    pl[0] = 8'h10;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    send_packet(8'h00, 8'h00, 1, 0, 20, 1'b1);
    send_packet(8'h00, 8'h00, 1, -1, 3, 1'b0);
`else
    send_packet(8'h00, 8'h00, 1, -1, 20, 1'b1);
`endif
  endtask

  task automatic test_reset_mid;
    int w0;
    for (int i = 0; i < 4; i++) pl[i] = 8'($urandom);
    put_byte(8'hA5); put_byte(8'h03); put_byte(8'h02); put_byte(8'h04);
    put_byte(pl[0]); put_byte(pl[1]);
    reset = 1'b1; rx_valid = 1'b1; rx_data = pl[2]; tx_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    err_exp = 0;
    check_idle_outputs("reset_mid");
    w0 = wr_seen;
    put_byte(pl[3]);
    repeat (20) @(negedge clk);
    checks++;
    if (wr_seen != w0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_quiet got writes=%0d tx_valid=%b busy=%b required 0 0 0",
               wr_seen - w0, tx_valid, busy);
    end
    for (int i = 0; i < 4; i++) pl[i] = 8'($urandom);
    send_packet(8'h10, 8'h04, 4, -1, 1, 1'b0);
  endtask

  task automatic test_random;
    logic [7:0] px, py;
    int len, chk;
    for (int n = 0; n < 20; n++) begin
      px  = ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, W)) : 8'($urandom_range(W - 1, 0));
      py  = ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, H)) : 8'($urandom_range(H - 1, 0));
      len = (n == 7) ? 256 : int'($urandom_range(12, 1));
      chk = ($urandom_range(4, 0) == 0) ? int'($urandom_range(255, 0)) : -1;
      for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
      send_packet(px, py, len, chk, int'($urandom_range(4, 0)), 1'($urandom_range(1, 0)));
    end
  endtask

  task automatic test_saturation;
    max_gap = 0;
    pl[0] = 8'h77;
    for (int n = 0; n < 260; n++) send_packet(8'hFF, 8'h00, 1, -1, 0, 1'b0);
    checks++;
    if (err_count !== 8'hFF) begin
      failures++;
      $display("FAIL err_saturate got %0d required 255", err_count);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_bad_coord;
    test_timeout;
    test_checksum;
    test_reset_mid;
    test_random;
    test_saturation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
